// File: rtl/mem_read_mc.sv
// rtl/mem_read_mc.sv - multi-channel AXI read-address scheduler and R-beat router
module mem_read_mc #(
    parameter int NUM_CH           = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int ID_WIDTH         = 4,
    parameter int LINE_BYTE_OFFSET = 6,
    parameter int BURST_WRAP       = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_CH-1:0]     i_req_valid,
    output logic [NUM_CH-1:0]     o_req_ready,
    input  logic [32*NUM_CH-1:0]  i_req_addr,
    input  logic [32*NUM_CH-1:0]  i_req_va,
    input  logic [8*NUM_CH-1:0]   i_req_len,
    input  logic [3*NUM_CH-1:0]   i_req_size,
    input  logic [NUM_CH-1:0]     i_ch_stall,
    input  logic                  i_write_process,
    input  logic [31:0]           i_write_address,
    output logic                  o_arvalid,
    output logic [31:0]           o_araddr,
    output logic [7:0]            o_arlen,
    output logic [2:0]            o_arsize,
    output logic [1:0]            o_arburst,
    output logic [ID_WIDTH-1:0]   o_arid,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    input  logic [31:0]           i_rdata,
    input  logic                  i_rlast,
    input  logic [ID_WIDTH-1:0]   i_rid,
    output logic                  o_rready,
    output logic [NUM_CH-1:0]     o_resp_valid,
    output logic [31:0]           o_resp_data,
    output logic [31:0]           o_resp_addr,
    output logic [31:0]           o_resp_va,
    output logic                  o_resp_last,
    output logic [NUM_CH-1:0]     o_ch_empty,
    output logic                  o_err
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int OW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OD = 1 << OW;
    localparam logic [FW:0] FONE = 1;
    localparam logic [OW:0] OONE = 1;
    localparam logic [OW:0] OMAX = MAX_OUTSTANDING[OW:0];
    localparam logic [7:0]  TMAX = MAX_OUTSTANDING[7:0];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] va;
        logic [7:0]  len;
        logic [2:0]  size;
    } req_t;

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     rr_q, rr_d, arch_q, arch_d;
    req_t              ar_q, ar_d;
    req_t              fifo_q [NUM_CH][FIFO_DEPTH];
    req_t              fifo_d [NUM_CH][FIFO_DEPTH];
    logic [FW:0]       fwp_q [NUM_CH], fwp_d [NUM_CH], frp_q [NUM_CH], frp_d [NUM_CH];
    req_t              out_q [NUM_CH][OD];
    req_t              out_d [NUM_CH][OD];
    logic [OW:0]       owp_q [NUM_CH], owp_d [NUM_CH], orp_q [NUM_CH], orp_d [NUM_CH];
    logic [7:0]        beat_q [NUM_CH], beat_d [NUM_CH];
    logic              err_q, err_d;
    logic [NUM_CH-1:0] empty_q, empty_d;

    logic [NUM_CH-1:0] fifo_full, elig, elig_ok, hit;
    req_t              head [NUM_CH];
    logic [OW:0]       ocnt [NUM_CH];
    logic [7:0]        total_out;
    logic              gnt_found, hit_any;
    logic [CW-1:0]     gnt_ch, cand, hit_ch;
    req_t              rhead;
    logic [31:0]       beat_off, wrap_mask, resp_addr, resp_va;
    logic              unused_write_low;

    assign unused_write_low = ^i_write_address[LINE_BYTE_OFFSET-1:0];

    // Queue status and issue eligibility per channel (write hazard is a cache-line compare)
    always_comb begin
        total_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_full[c] = (fwp_q[c][FW] != frp_q[c][FW]) && (fwp_q[c][FW-1:0] == frp_q[c][FW-1:0]);
            head[c]      = fifo_q[c][frp_q[c][FW-1:0]];
            ocnt[c]      = owp_q[c] - orp_q[c];
            total_out    = total_out + 8'(ocnt[c]);
            elig[c]      = (fwp_q[c] != frp_q[c]) && !i_ch_stall[c] && (ocnt[c] < OMAX) &&
                           !(i_write_process &&
                             (i_write_address[31:LINE_BYTE_OFFSET] == head[c].addr[31:LINE_BYTE_OFFSET]));
        end
        elig_ok = elig & {NUM_CH{total_out < TMAX}};
    end

    // Round-robin pick: first eligible channel at or after the pointer
    always_comb begin
        gnt_found = 1'b0;
        gnt_ch    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = CW'((int'(rr_q) + i) % NUM_CH);
            if (!gnt_found && elig_ok[cand]) begin
                gnt_found = 1'b1;
                gnt_ch    = cand;
            end
        end
    end

    // R routing by RID and beat address generation from the outstanding head
    always_comb begin
        hit     = '0;
        hit_any = 1'b0;
        hit_ch  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_rid == ID_WIDTH'(c) && ocnt[c] != '0) begin
                hit[c]  = 1'b1;
                hit_any = 1'b1;
                hit_ch  = CW'(c);
            end
        end
        rhead     = out_q[hit_ch][orp_q[hit_ch][OW-1:0]];
        beat_off  = 32'(beat_q[hit_ch]) << rhead.size;
        wrap_mask = ((32'(rhead.len) + 32'd1) << rhead.size) - 32'd1;
        if (BURST_WRAP != 0 && rhead.len != 8'd0) begin
            resp_addr = (rhead.addr & ~wrap_mask) | ((rhead.addr + beat_off) & wrap_mask);
            resp_va   = (rhead.va & ~wrap_mask) | ((rhead.va + beat_off) & wrap_mask);
        end else begin
            resp_addr = rhead.addr + beat_off;
            resp_va   = rhead.va + beat_off;
        end
    end

    // Next state: queue pushes, AR FSM, outstanding bookkeeping, sticky error, empty flags
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        arch_d  = arch_q;
        ar_d    = ar_q;
        fifo_d  = fifo_q;
        fwp_d   = fwp_q;
        frp_d   = frp_q;
        out_d   = out_q;
        owp_d   = owp_q;
        orp_d   = orp_q;
        beat_d  = beat_q;
        err_d   = err_q | (i_rvalid & ~hit_any);
        empty_d = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            if (i_req_valid[c] && !fifo_full[c]) begin
                fifo_d[c][fwp_q[c][FW-1:0]] = '{addr: i_req_addr[32*c +: 32], va: i_req_va[32*c +: 32],
                                                len: i_req_len[8*c +: 8], size: i_req_size[3*c +: 3]};
                fwp_d[c] = fwp_q[c] + FONE;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    ar_d    = head[gnt_ch];
                    arch_d  = gnt_ch;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_arready) begin
                    frp_d[arch_q] = frp_q[arch_q] + FONE;
                    out_d[arch_q][owp_q[arch_q][OW-1:0]] = ar_q;
                    owp_d[arch_q] = owp_q[arch_q] + OONE;
                    rr_d    = (arch_q == CW'(NUM_CH - 1)) ? '0 : arch_q + CW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_rvalid && hit_any) begin
            if (i_rlast) begin
                beat_d[hit_ch] = 8'd0;
                orp_d[hit_ch]  = orp_q[hit_ch] + OONE;
            end else begin
                beat_d[hit_ch] = beat_q[hit_ch] + 8'd1;
            end
        end

        for (int c = 0; c < NUM_CH; c++) begin
            empty_d[c] = (fwp_d[c] == frp_d[c]) && (owp_d[c] == orp_d[c]) &&
                         !(state_d == S_ISSUE && arch_d == CW'(c));
        end
    end

    // Control state registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            arch_q  <= '0;
            err_q   <= 1'b0;
            empty_q <= '1;
            for (int c = 0; c < NUM_CH; c++) begin
                fwp_q[c]  <= '0;
                frp_q[c]  <= '0;
                owp_q[c]  <= '0;
                orp_q[c]  <= '0;
                beat_q[c] <= '0;
            end
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            arch_q  <= arch_d;
            err_q   <= err_d;
            empty_q <= empty_d;
            fwp_q   <= fwp_d;
            frp_q   <= frp_d;
            owp_q   <= owp_d;
            orp_q   <= orp_d;
            beat_q  <= beat_d;
        end
    end

    // Payload storage; only meaningful where pointers say so, so no reset
    always_ff @(posedge i_clk) begin
        fifo_q <= fifo_d;
        out_q  <= out_d;
        ar_q   <= ar_d;
    end

    assign o_req_ready  = ~fifo_full;
    assign o_arvalid    = (state_q == S_ISSUE);
    assign o_araddr     = ar_q.addr;
    assign o_arlen      = ar_q.len;
    assign o_arsize     = ar_q.size;
    assign o_arburst    = (ar_q.len == 8'd0) ? 2'b00 : ((BURST_WRAP != 0) ? 2'b10 : 2'b01);
    assign o_arid       = ID_WIDTH'(arch_q);
    assign o_rready     = 1'b1;
    assign o_resp_valid = hit & {NUM_CH{i_rvalid}};
    assign o_resp_data  = i_rdata;
    assign o_resp_addr  = resp_addr;
    assign o_resp_va    = resp_va;
    assign o_resp_last  = i_rlast;
    assign o_ch_empty   = empty_q;
    assign o_err        = err_q;
endmodule

// File: tb/tb_mem_read_mc.sv
// tb/tb_mem_read_mc.sv - scoreboard bench for mem_read_mc
module tb_mem_read_mc;
    localparam int NUM_CH = 2;
    localparam int IDW    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 i_rst;
    logic [NUM_CH-1:0]    i_req_valid, o_req_ready, i_ch_stall, o_resp_valid, o_ch_empty;
    logic [32*NUM_CH-1:0] i_req_addr, i_req_va;
    logic [8*NUM_CH-1:0]  i_req_len;
    logic [3*NUM_CH-1:0]  i_req_size;
    logic                 i_write_process, o_arvalid, i_arready, i_rvalid, i_rlast, o_rready;
    logic                 o_resp_last, o_err;
    logic [31:0]          i_write_address, o_araddr, i_rdata, o_resp_data, o_resp_addr, o_resp_va;
    logic [7:0]           o_arlen;
    logic [2:0]           o_arsize;
    logic [1:0]           o_arburst;
    logic [IDW-1:0]       o_arid, i_rid;

    mem_read_mc #(.NUM_CH(NUM_CH), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4), .ID_WIDTH(IDW),
                  .LINE_BYTE_OFFSET(6), .BURST_WRAP(1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_va(i_req_va), .i_req_len(i_req_len), .i_req_size(i_req_size),
        .i_ch_stall(i_ch_stall), .i_write_process(i_write_process), .i_write_address(i_write_address),
        .o_arvalid(o_arvalid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arburst(o_arburst), .o_arid(o_arid), .i_arready(i_arready), .i_rvalid(i_rvalid),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rid(i_rid), .o_rready(o_rready),
        .o_resp_valid(o_resp_valid), .o_resp_data(o_resp_data), .o_resp_addr(o_resp_addr),
        .o_resp_va(o_resp_va), .o_resp_last(o_resp_last), .o_ch_empty(o_ch_empty), .o_err(o_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] va;
        logic        last;
    } beat_t;

    beat_t exp_q [NUM_CH][$];
    int checks = 0;
    int failures = 0;

    // Expected beat addresses of a WRAP burst: step by 1<<size, fold back at the window end
    task automatic push_burst_exp(input int ch, input logic [31:0] addr, input logic [31:0] va,
                                  input logic [7:0] len, input logic [2:0] size);
        logic [31:0] win, abase, vbase, a, v;
        win   = (32'(len) + 32'd1) << size;
        abase = addr - (addr % win);
        vbase = va - (va % win);
        a = addr;
        v = va;
        for (int i = 0; i <= int'(len); i++) begin
            exp_q[ch].push_back('{addr: a, va: v, last: (i == int'(len))});
            a = a + (32'd1 << size);
            v = v + (32'd1 << size);
            if (len != 8'd0 && a >= abase + win) a = a - win;
            if (len != 8'd0 && v >= vbase + win) v = v - win;
        end
    endtask

    task automatic set_req(input int ch, input logic [31:0] addr, input logic [31:0] va,
                           input logic [7:0] len, input logic [2:0] size);
        i_req_addr[32*ch +: 32] = addr;
        i_req_va[32*ch +: 32]   = va;
        i_req_len[8*ch +: 8]    = len;
        i_req_size[3*ch +: 3]   = size;
    endtask

    task automatic accept_ar(output logic ok, output logic [31:0] addr, output logic [7:0] len,
                             output logic [2:0] size, output logic [1:0] burst, output logic [IDW-1:0] id);
        ok = 1'b0; addr = '0; len = '0; size = '0; burst = '0; id = '0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (o_arvalid) begin
                ok = 1'b1; addr = o_araddr; len = o_arlen; size = o_arsize; burst = o_arburst; id = o_arid;
                i_arready = 1'b1;
                @(negedge clk);
                i_arready = 1'b0;
            end
        end
    endtask

    task automatic send_beat(input logic [IDW-1:0] rid, input logic [31:0] data, input logic last,
                             output logic [NUM_CH-1:0] rv, output logic [31:0] ra, output logic [31:0] rva,
                             output logic [31:0] rd, output logic rl);
        i_rvalid = 1'b1; i_rid = rid; i_rdata = data; i_rlast = last;
        #1;
        rv = o_resp_valid; ra = o_resp_addr; rva = o_resp_va; rd = o_resp_data; rl = o_resp_last;
        @(negedge clk);
        i_rvalid = 1'b0; i_rlast = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_req_valid = '0; i_req_addr = '0; i_req_va = '0; i_req_len = '0; i_req_size = '0;
        i_ch_stall = '0; i_write_process = 1'b0; i_write_address = '0; i_arready = 1'b0;
        i_rvalid = 1'b0; i_rdata = '0; i_rlast = 1'b0; i_rid = '0;
        for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_arvalid !== 1'b0 || o_resp_valid !== 2'b00 || o_err !== 1'b0 || o_ch_empty !== 2'b11 ||
            o_rready !== 1'b1 || o_req_ready !== 2'b11) begin
            failures++;
            $display("FAIL reset: arvalid=%b resp_valid=%b err=%b ch_empty=%b rready=%b req_ready=%b want 0 00 0 11 1 11",
                     o_arvalid, o_resp_valid, o_err, o_ch_empty, o_rready, o_req_ready);
        end
    endtask

    task automatic test_rr_order();
        logic ok; logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [IDW-1:0] id;
        logic [31:0] exp_addr [4];
        logic [NUM_CH-1:0] rv, erv; logic [31:0] ra, rva, rd, d; logic rl; beat_t e;
        exp_addr[0] = 32'h1000_0000; exp_addr[1] = 32'h2000_0000;
        exp_addr[2] = 32'h1000_1000; exp_addr[3] = 32'h2000_1000;
        for (int p = 0; p < 2; p++) begin
            set_req(0, exp_addr[2*p], 32'h8000_0000 + 32'(p) * 32'h1000, 8'd15, 3'd2);
            set_req(1, exp_addr[2*p+1], 32'h8100_0000 + 32'(p) * 32'h1000, 8'd15, 3'd2);
            push_burst_exp(0, exp_addr[2*p], 32'h8000_0000 + 32'(p) * 32'h1000, 8'd15, 3'd2);
            push_burst_exp(1, exp_addr[2*p+1], 32'h8100_0000 + 32'(p) * 32'h1000, 8'd15, 3'd2);
            i_req_valid = 2'b11;
            @(negedge clk);
        end
        i_req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            accept_ar(ok, a, l, s, b, id);
            checks++;
            if (!ok || a !== exp_addr[k] || id !== IDW'(k % 2) || b !== 2'b10 || l !== 8'd15 || s !== 3'd2) begin
                failures++;
                $display("FAIL rr_ar%0d: ok=%b addr=%h id=%0d burst=%b len=%0d size=%0d want addr=%h id=%0d burst=10 len=15 size=2",
                         k, ok, a, id, b, l, s, exp_addr[k], k % 2);
            end
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            while (exp_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front(); d = $urandom; erv = '0; erv[ch] = 1'b1;
                send_beat(IDW'(ch), d, e.last, rv, ra, rva, rd, rl);
                checks++;
                if (rv !== erv || ra !== e.addr || rva !== e.va || rd !== d || rl !== e.last) begin
                    failures++;
                    $display("FAIL rr_beat ch%0d: valid=%b addr=%h va=%h data=%h last=%b want %b %h %h %h %b",
                             ch, rv, ra, rva, rd, rl, erv, e.addr, e.va, d, e.last);
                end
            end
        end
    endtask

    task automatic test_write_hazard();
        logic ok; logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [IDW-1:0] id;
        logic [NUM_CH-1:0] rv, erv; logic [31:0] ra, rva, rd, d; logic rl; beat_t e;
        int seen0, seen1;
        seen0 = 0; seen1 = 0;
        i_write_process = 1'b1; i_write_address = 32'h1000_0078;
        set_req(0, 32'h1000_0040, 32'h8800_0040, 8'd3, 3'd2);
        set_req(1, 32'h2000_0200, 32'h8900_0200, 8'd3, 3'd2);
        push_burst_exp(0, 32'h1000_0040, 32'h8800_0040, 8'd3, 3'd2);
        push_burst_exp(1, 32'h2000_0200, 32'h8900_0200, 8'd3, 3'd2);
        i_req_valid = 2'b11; i_arready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            i_req_valid = '0;
            if (o_arvalid) begin
                if (o_arid == IDW'(1)) seen1++;
                else seen0++;
            end
        end
        i_arready = 1'b0; i_write_process = 1'b0;
        checks++;
        if (seen1 != 1 || seen0 != 0) begin
            failures++;
            $display("FAIL hazard_during_write: ch1_ars=%0d ch0_ars=%0d want 1 and 0", seen1, seen0);
        end
        accept_ar(ok, a, l, s, b, id);
        checks++;
        if (!ok || id !== IDW'(0) || a !== 32'h1000_0040) begin
            failures++;
            $display("FAIL hazard_release: ok=%b id=%0d addr=%h want 1 0 10000040", ok, id, a);
        end
        for (int ch = NUM_CH - 1; ch >= 0; ch--) begin
            while (exp_q[ch].size() > 0) begin
                e = exp_q[ch].pop_front(); d = $urandom; erv = '0; erv[ch] = 1'b1;
                send_beat(IDW'(ch), d, e.last, rv, ra, rva, rd, rl);
                checks++;
                if (rv !== erv || ra !== e.addr || rva !== e.va || rd !== d || rl !== e.last) begin
                    failures++;
                    $display("FAIL hazard_beat ch%0d: valid=%b addr=%h va=%h last=%b want %b %h %h %b",
                             ch, rv, ra, rva, rl, erv, e.addr, e.va, e.last);
                end
            end
        end
    endtask

    task automatic test_ar_hold();
        logic [NUM_CH-1:0] rv, erv; logic [31:0] ra, rva, rd, d; logic rl; beat_t e;
        set_req(0, 32'h3000_0100, 32'h8a00_0100, 8'd7, 3'd2);
        push_burst_exp(0, 32'h3000_0100, 32'h8a00_0100, 8'd7, 3'd2);
        i_req_valid = 2'b01;
        @(negedge clk);
        i_req_valid = '0;
        for (int k = 0; k < 20 && !o_arvalid; k++) @(negedge clk);
        i_ch_stall = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_arvalid !== 1'b1 || o_araddr !== 32'h3000_0100 || o_arlen !== 8'd7) begin
                failures++;
                $display("FAIL ar_hold cycle%0d: arvalid=%b addr=%h len=%0d want 1 30000100 7", k, o_arvalid, o_araddr, o_arlen);
            end
            if (k == 4) i_arready = 1'b1;
        end
        @(negedge clk);
        i_arready = 1'b0; i_ch_stall = '0;
        checks++;
        if (o_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL ar_hold_handshake: arvalid=%b want 0", o_arvalid);
        end
        while (exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front(); d = $urandom; erv = 2'b01;
            send_beat(IDW'(0), d, e.last, rv, ra, rva, rd, rl);
            checks++;
            if (rv !== erv || ra !== e.addr || rva !== e.va || rl !== e.last) begin
                failures++;
                $display("FAIL hold_beat: valid=%b addr=%h va=%h last=%b want %b %h %h %b", rv, ra, rva, rl, erv, e.addr, e.va, e.last);
            end
        end
    endtask

    task automatic test_wrap_burst();
        logic ok; logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [IDW-1:0] id;
        logic [NUM_CH-1:0] rv; logic [31:0] ra, rva, rd, d; logic rl; beat_t e; int n;
        set_req(0, 32'h0000_0038, 32'h7000_0038, 8'd15, 3'd2);
        push_burst_exp(0, 32'h0000_0038, 32'h7000_0038, 8'd15, 3'd2);
        i_req_valid = 2'b01;
        @(negedge clk);
        i_req_valid = '0;
        accept_ar(ok, a, l, s, b, id);
        checks++;
        if (!ok || a !== 32'h38 || b !== 2'b10 || id !== IDW'(0)) begin
            failures++;
            $display("FAIL wrap_ar: ok=%b addr=%h burst=%b id=%0d want 1 00000038 10 0", ok, a, b, id);
        end
        n = 0;
        while (exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front(); d = $urandom;
            send_beat(IDW'(0), d, e.last, rv, ra, rva, rd, rl);
            n++;
            checks++;
            if (rv !== 2'b01 || ra !== e.addr || rva !== e.va || rl !== e.last) begin
                failures++;
                $display("FAIL wrap_beat%0d: valid=%b addr=%h va=%h last=%b want 01 %h %h %b", n, rv, ra, rva, rl, e.addr, e.va, e.last);
            end
            if (n == 8) begin
                checks++;
                if (o_ch_empty[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL wrap_mid_empty: ch_empty0=%b want 0", o_ch_empty[0]);
                end
            end
        end
        checks++;
        if (n != 16 || o_ch_empty[0] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_end_empty: beats=%0d ch_empty0=%b want 16 1", n, o_ch_empty[0]);
        end
    endtask

    task automatic test_interleave();
        logic ok; logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [IDW-1:0] id;
        logic [NUM_CH-1:0] rv, erv; logic [31:0] ra, rva, rd, d; logic rl; beat_t e;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            set_req(ch, (ch == 0) ? 32'h4000_0010 : 32'h5000_0008, (ch == 0) ? 32'h9000_0010 : 32'ha000_0008, 8'd3, 3'd2);
            push_burst_exp(ch, (ch == 0) ? 32'h4000_0010 : 32'h5000_0008, (ch == 0) ? 32'h9000_0010 : 32'ha000_0008, 8'd3, 3'd2);
            i_req_valid = '0; i_req_valid[ch] = 1'b1;
            @(negedge clk);
            i_req_valid = '0;
            accept_ar(ok, a, l, s, b, id);
            checks++;
            if (!ok || id !== IDW'(ch)) begin
                failures++;
                $display("FAIL interleave_ar%0d: ok=%b id=%0d want 1 %0d", ch, ok, id, ch);
            end
        end
        for (int k = 0; k < 8; k++) begin
            int ch;
            ch = (k % 2 == 0) ? 1 : 0;
            e = exp_q[ch].pop_front(); d = $urandom; erv = '0; erv[ch] = 1'b1;
            send_beat(IDW'(ch), d, e.last, rv, ra, rva, rd, rl);
            checks++;
            if (rv !== erv || ra !== e.addr || rva !== e.va || rd !== d || rl !== e.last) begin
                failures++;
                $display("FAIL interleave_beat%0d ch%0d: valid=%b addr=%h va=%h last=%b want %b %h %h %b",
                         k, ch, rv, ra, rva, rl, erv, e.addr, e.va, e.last);
            end
        end
    endtask

    task automatic test_full_and_limit();
        logic ok; logic [31:0] a; logic [7:0] l; logic [2:0] s; logic [1:0] b; logic [IDW-1:0] id;
        logic [NUM_CH-1:0] rv; logic [31:0] ra, rva, rd, d; logic rl; beat_t e; int seen;
        i_arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_req(0, 32'h6000_0000 + 32'(k) * 32'h100, 32'h6100_0000 + 32'(k) * 32'h100, 8'd0, 3'd2);
            push_burst_exp(0, 32'h6000_0000 + 32'(k) * 32'h100, 32'h6100_0000 + 32'(k) * 32'h100, 8'd0, 3'd2);
            i_req_valid = 2'b01;
            @(negedge clk);
        end
        checks++;
        if (o_req_ready !== 2'b10) begin
            failures++;
            $display("FAIL queue_full_ready: req_ready=%b want 10", o_req_ready);
        end
        set_req(0, 32'h6000_0f00, 32'h6100_0f00, 8'd0, 3'd2);
        @(negedge clk);
        i_req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            accept_ar(ok, a, l, s, b, id);
            checks++;
            if (!ok || a !== 32'h6000_0000 + 32'(k) * 32'h100 || b !== 2'b00 || l !== 8'd0) begin
                failures++;
                $display("FAIL full_ar%0d: ok=%b addr=%h burst=%b len=%0d want addr=%h burst=00 len=0",
                         k, ok, a, b, l, 32'h6000_0000 + 32'(k) * 32'h100);
            end
        end
        set_req(0, 32'h6000_0400, 32'h6100_0400, 8'd0, 3'd2);
        push_burst_exp(0, 32'h6000_0400, 32'h6100_0400, 8'd0, 3'd2);
        i_req_valid = 2'b01;
        @(negedge clk);
        i_req_valid = '0; i_arready = 1'b1; seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (o_arvalid) seen++;
        end
        i_arready = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL outstanding_limit: ars_issued=%0d want 0", seen);
        end
        e = exp_q[0].pop_front(); d = $urandom;
        send_beat(IDW'(0), d, e.last, rv, ra, rva, rd, rl);
        checks++;
        if (rv !== 2'b01 || ra !== e.addr || rl !== 1'b1) begin
            failures++;
            $display("FAIL limit_beat: valid=%b addr=%h last=%b want 01 %h 1", rv, ra, rl, e.addr);
        end
        accept_ar(ok, a, l, s, b, id);
        checks++;
        if (!ok || a !== 32'h6000_0400) begin
            failures++;
            $display("FAIL limit_release: ok=%b addr=%h want 1 60000400", ok, a);
        end
        while (exp_q[0].size() > 0) begin
            e = exp_q[0].pop_front(); d = $urandom;
            send_beat(IDW'(0), d, e.last, rv, ra, rva, rd, rl);
            checks++;
            if (rv !== 2'b01 || ra !== e.addr || rva !== e.va || rl !== e.last) begin
                failures++;
                $display("FAIL full_beat: valid=%b addr=%h va=%h last=%b want 01 %h %h %b", rv, ra, rva, rl, e.addr, e.va, e.last);
            end
        end
    endtask

    task automatic test_bad_id();
        logic [NUM_CH-1:0] rv; logic [31:0] ra, rva, rd; logic rl;
        checks++;
        if (o_err !== 1'b0) begin
            failures++;
            $display("FAIL err_before: err=%b want 0", o_err);
        end
        send_beat(IDW'(3), 32'hdead_beef, 1'b1, rv, ra, rva, rd, rl);
        checks++;
        if (rv !== 2'b00 || o_err !== 1'b1) begin
            failures++;
            $display("FAIL bad_rid: valid=%b err=%b want 00 1", rv, o_err);
        end
        send_beat(IDW'(1), 32'h1234_5678, 1'b0, rv, ra, rva, rd, rl);
        repeat (3) @(negedge clk);
        checks++;
        if (rv !== 2'b00 || o_err !== 1'b1) begin
            failures++;
            $display("FAIL no_outstanding_beat: valid=%b err=%b want 00 1", rv, o_err);
        end
    endtask

    initial begin
        fork
            begin
                #1_000_000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_rr_order();
        test_write_hazard();
        test_ar_hold();
        test_wrap_burst();
        test_interleave();
        test_full_and_limit();
        test_bad_id();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_read_mc.md
Name: mem_read_mc

Overview:
Multi-channel AXI read-address scheduler and response router for the memory-management subsystem. It is the parametrised successor of the two-channel I/D refill reader. It queues refill requests from NUM_CH requesters (I-cache, D-cache, uncached, prefetch) in per-channel FIFOs and issues them on one AXI AR channel with round-robin fairness. Multiple bursts may be in flight at once, and R beats are routed back to the owning channel by RID.

Parameters:
NUM_CH, 2, number of requesting channels (1..4)
FIFO_DEPTH, 4, per-channel request queue depth (power of 2, >=2)
MAX_OUTSTANDING, 4, max bursts issued without RLAST, per channel and in total (power of 2, <=8)
ID_WIDTH, 4, AXI ID width (>= clog2(NUM_CH))
LINE_BYTE_OFFSET, 6, cache-line byte offset used for the write-hazard compare
BURST_WRAP, 1, 1: bursts use WRAP (2'b10); 0: bursts use INCR (2'b01)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_valid  in  NUM_CH  per-channel request valid
o_req_ready  out  NUM_CH  per-channel queue not full
i_req_addr  in  32*NUM_CH  physical start address
i_req_va  in  32*NUM_CH  virtual start address
i_req_len  in  8*NUM_CH  AXI arlen
i_req_size  in  3*NUM_CH  AXI arsize
i_ch_stall  in  NUM_CH  block issue from this channel
i_write_process  in  1  a write burst is in progress
i_write_address  in  32  address of the in-progress write
o_arvalid/o_araddr(32)/o_arlen(8)/o_arsize(3)/o_arburst(2)/o_arid(ID_WIDTH)  out  AR channel
i_arready  in  1
i_rvalid/i_rdata(32)/i_rlast/i_rid(ID_WIDTH)  in  R channel
o_rready  out  1  constant 1
o_resp_valid  out  NUM_CH  one-hot beat strobe to the owning channel
o_resp_data  out  32  beat data
o_resp_addr  out  32  physical address of the current beat
o_resp_va  out  32  virtual address of the current beat
o_resp_last  out  1  last beat of the burst
o_ch_empty  out  NUM_CH  channel has nothing queued and nothing outstanding
o_err  out  1  sticky: an R beat arrived with no matching outstanding burst

Behaviour:
- Reset: all FIFOs and outstanding queues are cleared; RR pointer=0; o_arvalid=0; o_resp_valid=0; o_err=0; o_ch_empty=all ones; o_rready=1.
- Accept: a push occurs when i_req_valid&o_req_ready. o_req_ready=!full; a full queue stays not-ready even if it pops in the same cycle (no bypass). A pushed entry becomes eligible the following cycle.
- Eligibility of channel c requires all of:
  - queue c is non-empty;
  - !i_ch_stall[c];
  - channel c's outstanding count < MAX_OUTSTANDING;
  - no write hazard: !(i_write_process && i_write_address[31:LINE_BYTE_OFFSET]==head_addr[31:LINE_BYTE_OFFSET]).
- AR FSM:
  - IDLE: if any channel is eligible, grant the first eligible channel at or after the RR pointer. Latch the head into AR registers; o_arvalid=1 next cycle; go to ISSUE.
  - ISSUE: the payload and o_arvalid are held stable regardless of stall or hazard changes (AXI rule). On i_arready: pop the head, push {addr,va,size,len} into channel c's outstanding queue, set RR pointer=c+1 mod NUM_CH, go to IDLE.
  - Minimum spacing is one AR every 2 cycles.
- AR encoding: o_arid=c, zero-extended. o_arburst=2'b00 if arlen==0, else 2'b10 when BURST_WRAP=1 or 2'b01 when BURST_WRAP=0.
- R routing (combinational, same cycle as i_rvalid):
  - Channel c=i_rid; o_resp_valid[c]=i_rvalid only if c<NUM_CH and outstanding(c)>0.
  - o_resp_data=i_rdata; o_resp_last=i_rlast.
- Beat address: the first beat uses the stored start address. Each later beat adds 1<<size. With WRAP, the address wraps within an aligned window of (len+1)<<size bytes; the VA is tracked identically. The beat counter resets on rlast.
- RLAST pops channel c's outstanding head. An AR handshake and an RLAST in the same cycle on the same channel leave the count unchanged.
- An unmatched beat (bad ID or zero outstanding) is dropped: o_resp_valid=0 and o_err is set until reset.
- o_ch_empty[c] is registered: queue c is empty, channel c's outstanding count is 0, and channel c is not in the ISSUE slot.
- Reset mid-burst discards all state. The bus is reset with the core, so no beats are expected afterwards.

Test Plan:
- NUM_CH=2, ch0 and ch1 each push 2 requests (len=15, size=2) at the same time -> AR order ch0,ch1,ch0,ch1; arid 0,1,0,1; arburst=2'b10.
- ch0 addr 0x1000_0040, i_write_process=1 with write address 0x1000_0078 for 10 cycles, ch1 queued -> ch1 issues first; ch0 issues only after the write drops.
- arready held low 5 cycles while i_ch_stall[0] rises after arvalid -> araddr/arlen remain constant; handshake completes on the 5th cycle.
- WRAP burst start 0x38, len=15, size=2 -> o_resp_addr 0x38,0x3C,0x00,...,0x34; o_resp_last on beat 16; o_ch_empty[0]=1 the cycle after.
- ch1 burst issued after ch0, responses interleaved with ch1 first -> o_resp_valid one-hot matches RID; the address sequence of each channel is independent.
- Beat with rid=3 (NUM_CH=2) -> no o_resp_valid; o_err=1 and stays 1 until i_rst.
